mul_div_unit: RTL and testbench
===============================

Name: mul_div_unit

Overview:
- Multi-cycle multiply/divide engine in the EX stage of the MIPS pipeline.
- Executes MULT, MULTU, DIV and DIVU, and stalls the pipeline while it works.
- On completion, drives the HI/LO register file write port: hiwdata, lowdata and a 2-bit wen.
- Is the producer of everything the HI/LO file stores from arithmetic.

Parameters:
- WIDTH, 32, operand width; results are WIDTH-bit hi and WIDTH-bit lo.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  EX-stage instruction is a mult/div; held until stall_o drops.
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start.
- src1  input  WIDTH  rs operand (multiplicand/dividend); sampled with start.
- src2  input  WIDTH  rt operand (multiplier/divisor); sampled with start.
- flush  input  1  exception/flush of the EX instruction; cancels the operation.
- stall_o  output  1  pipeline stall request.
- wen  output  2  HI/LO write enable; bit1 = hi, bit0 = lo.
- hiwdata  output  WIDTH  hi result (product[63:32] / remainder).
- lowdata  output  WIDTH  lo result (product[31:0] / quotient).

Behaviour:
- Reset (asynchronous, high): state=IDLE, counter=0, wen=00, hiwdata=0, lowdata=0. stall_o is 0 because start is ignored while reset is high.
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - start & !flush: latch op, |src1|/|src2| (magnitudes for signed ops), and result signs.
  - Transitions: MULT/MULTU -> MUL; DIV/DIVU with src2==0 -> DONE directly; otherwise -> DIV with counter=WIDTH.
- MUL: one cycle; registers the full 2*WIDTH unsigned product of the magnitudes -> DONE.
- DIV:
  - Restoring radix-2, one quotient bit per cycle, MSB first.
  - Partial remainder is WIDTH+1 bits; counter decrements; counter==1 -> DONE after that iteration.
- Sign fixup (applied when forming DONE outputs):
  - MULT: negate product if signs differ.
  - DIV: quotient negated if signs differ; remainder takes the dividend's sign.
  - 0x80000000 / -1 gives lo=0x80000000, hi=0 (magnitude arithmetic wraps naturally).
- Divide by zero: hi=src1 (raw dividend), lo=all ones, for both DIV and DIVU.
- DONE:
  - wen=11 for exactly this cycle, with hiwdata/lowdata valid; next state is IDLE.
  - start seen in DONE is ignored: it is the same instruction still in EX.
- stall_o = (state==IDLE & start & !flush) | state==MUL | state==DIV. It is 0 in DONE, so the instruction advances in the DONE cycle.
- wen is 00 in every state other than DONE; hiwdata/lowdata hold their last values.
- Latency, with start accepted in cycle T:
  - MULT/MULTU: wen in T+2.
  - DIV/DIVU: wen in T+WIDTH+1 (T+33 for WIDTH=32).
  - Divide by zero: wen in T+1.
- flush in MUL or DIV: next state IDLE, no write ever issued, stall_o falls in the same cycle (combinational).
- flush in DONE: wen forced to 00 that cycle, then IDLE.
- Back-to-back: start in the cycle after DONE is accepted normally (IDLE).
- reset asserted mid-operation: immediate return to IDLE, outputs cleared, no write.

Decomposition:
- Shared package holds:
  - op encodings (OP_MULT=2'b00, OP_MULTU=2'b01, OP_DIV=2'b10, OP_DIVU=2'b11);
  - state encodings (IDLE, MUL, DIV, DONE);
  - the WIDTH default.
- One sub-module is natural: div_iter. It is a combinational single-step restoring-division cell (partial remainder, next dividend bit, divisor -> new remainder, quotient bit), used by the DIV state each cycle.
- The multiplier stays inline as a registered `*`.

Test Plan:
- MULT src1=0xFFFFFFFD (-3), src2=5 -> stall_o high T..T+1; in T+2 wen=11, hiwdata=0xFFFFFFFF, lowdata=0xFFFFFFF1.
- MULTU src1=src2=0xFFFFFFFF -> T+2: hiwdata=0xFFFFFFFE, lowdata=0x00000001.
- DIV signed cases:
  - src1=0xFFFFFFF9 (-7), src2=2 -> stall_o high 33 cycles; T+33: lowdata=0xFFFFFFFD, hiwdata=0xFFFFFFFF.
  - DIV 0x80000000/0xFFFFFFFF -> lowdata=0x80000000, hiwdata=0.
- DIVU 100/7 -> T+33: lowdata=14, hiwdata=2. DIVU 0x12345678/0 -> T+1: hiwdata=0x12345678, lowdata=0xFFFFFFFF, stall_o high only in T.
- Cancellation:
  - DIV started, flush at T+10 -> stall_o low at T+10, wen stays 00 through T+40.
  - MULT with flush in DONE cycle -> wen=00.
  - reset pulse at T+5 of a DIV -> outputs 0, state IDLE, no write.
- start held high through DONE, then a new MULT issued the next cycle -> exactly one wen pulse per instruction; second result correct at its own T+2.

Source files
------------

// File: rtl/mul_div_unit_pkg.sv
// Shared encodings for the EX-stage multiply/divide engine.
package mul_div_unit_pkg;

  localparam int WIDTH_DEF = 32;

  // op field as decoded in EX; bit1 selects divide, bit0 selects unsigned
  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MUL  = 2'b01,
    DIV  = 2'b10,
    DONE = 2'b11
  } state_e;

endpackage

// File: rtl/mul_div_unit_div_iter.sv
// One restoring-division step: shift in the next dividend bit, try to
// subtract the divisor, keep the difference only if it did not borrow.
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH:0]   rem_o,
  output logic             q_o
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;

  // rem_i < divisor, so the shifted value never reaches bit WIDTH+1 and
  // the top bit of the difference is a clean borrow flag
  always_comb begin
    shifted = {rem_i, bit_i};
    diff    = shifted - {2'b00, divisor_i};
    q_o     = ~diff[WIDTH+1];
    rem_o   = q_o ? diff[WIDTH:0] : shifted[WIDTH:0];
  end

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU engine feeding the HI/LO write port.
// Works on magnitudes and applies sign fixup when the result is latched.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic             flush,
  output logic             stall_o,
  output logic [1:0]       wen,
  output logic [WIDTH-1:0] hiwdata,
  output logic [WIDTH-1:0] lowdata
);

  localparam int CW = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q;        // multiplicand, or dividend shifting into quotient
  logic [WIDTH-1:0] b_q;        // multiplier / divisor magnitude
  logic             neg_res_q;  // operand signs differ (signed ops only)
  logic             neg_rem_q;  // dividend negative (signed ops only)
  logic [CW-1:0]    cnt_q;
  logic [WIDTH:0]   rem_q;
  logic [WIDTH-1:0] hi_q, lo_q;

  logic               accept, is_mul, is_signed, dz;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH:0]     rem_nxt;
  logic               q_bit;
  logic [WIDTH-1:0]   quo_fin, quo_fix, rem_fix;

  assign accept    = (state_q == IDLE) && start && !flush;
  assign is_mul    = ~op[1];
  assign is_signed = ~op[0];
  assign dz        = (src2 == '0);
  assign a_mag     = (is_signed && src1[WIDTH-1]) ? -src1 : src1;
  assign b_mag     = (is_signed && src2[WIDTH-1]) ? -src2 : src2;

  assign prod     = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
  assign prod_fix = neg_res_q ? -prod : prod;

  div_iter #(.WIDTH(WIDTH)) u_div_iter (
    .rem_i     (rem_q),
    .bit_i     (a_q[WIDTH-1]),
    .divisor_i (b_q),
    .rem_o     (rem_nxt),
    .q_o       (q_bit)
  );

  // final-iteration results; 0x80000000 / -1 wraps back to 0x80000000 here
  assign quo_fin = {a_q[WIDTH-2:0], q_bit};
  assign quo_fix = neg_res_q ? -quo_fin : quo_fin;
  assign rem_fix = neg_rem_q ? -rem_nxt[WIDTH-1:0] : rem_nxt[WIDTH-1:0];

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // next state, stall request and write enable
  always_comb begin
    state_d = state_q;
    stall_o = 1'b0;
    wen     = 2'b00;
    case (state_q)
      IDLE: begin
        if (accept && !reset) begin
          stall_o = 1'b1;
          if (is_mul)  state_d = MUL;
          else if (dz) state_d = DONE;
          else         state_d = DIV;
        end
      end
      MUL: begin
        if (flush) state_d = IDLE;
        else begin
          stall_o = 1'b1;
          state_d = DONE;
        end
      end
      DIV: begin
        if (flush) state_d = IDLE;
        else begin
          stall_o = 1'b1;
          if (cnt_q == CW'(1)) state_d = DONE;
        end
      end
      DONE: begin
        // start still high here belongs to the retiring instruction
        wen     = flush ? 2'b00 : 2'b11;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // operand capture, iteration state and result registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q       <= '0;
      b_q       <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      cnt_q     <= '0;
      rem_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            a_q       <= a_mag;
            b_q       <= b_mag;
            neg_res_q <= is_signed & (src1[WIDTH-1] ^ src2[WIDTH-1]);
            neg_rem_q <= is_signed & src1[WIDTH-1];
            cnt_q     <= CW'(WIDTH);
            rem_q     <= '0;
            if (!is_mul && dz) begin
              hi_q <= src1;
              lo_q <= '1;
            end
          end
        end
        MUL: begin
          if (!flush) {hi_q, lo_q} <= prod_fix;
        end
        DIV: begin
          if (!flush) begin
            a_q   <= quo_fin;
            rem_q <= rem_nxt;
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
              lo_q <= quo_fix;
              hi_q <= rem_fix;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign hiwdata = hi_q;
  assign lowdata = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: the driver pushes model results,
// a negedge monitor pops them whenever the HI/LO write port fires.
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         flush = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] src1 = '0;
  logic [W-1:0] src2 = '0;
  logic         stall_o;
  logic [1:0]   wen;
  logic [W-1:0] hiwdata, lowdata;

  mul_div_unit #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .src1    (src1),
    .src2    (src2),
    .flush   (flush),
    .stall_o (stall_o),
    .wen     (wen),
    .hiwdata (hiwdata),
    .lowdata (lowdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           due;
    int           lat;
  } exp_t;

  exp_t sbq[$];

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // reference: plain 64-bit arithmetic on the architectural definition
  function automatic exp_t model(logic [1:0] o, logic [W-1:0] a, logic [W-1:0] b);
    exp_t        e;
    longint      sa, sb, q, m;
    logic [63:0] r;
    sa = $signed(a);
    sb = $signed(b);
    e.due = 0;
    case (o)
      2'b00: begin r = sa * sb; e.hi = r[63:32]; e.lo = r[31:0]; e.lat = 2; end
      2'b01: begin r = {32'b0, a} * {32'b0, b}; e.hi = r[63:32]; e.lo = r[31:0]; e.lat = 2; end
      default: begin
        if (b == 0) begin
          e.hi = a; e.lo = '1; e.lat = 1;
        end else if (o == 2'b10) begin
          q = sa / sb; m = sa % sb;
          r = q; e.lo = r[31:0];
          r = m; e.hi = r[31:0];
          e.lat = 33;
        end else begin
          e.lo = a / b; e.hi = a % b; e.lat = 33;
        end
      end
    endcase
    return e;
  endfunction

  // called just after a posedge; leaves start low just after the posedge
  // that retires the instruction, so consecutive calls are back-to-back
  task automatic issue(logic [1:0] o, logic [W-1:0] a, logic [W-1:0] b);
    exp_t e;
    int   nst;
    bit   done;
    start = 1'b1; op = o; src1 = a; src2 = b;
    e = model(o, a, b);
    e.due = cyc + e.lat;
    sbq.push_back(e);
    nst = 0; done = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (stall_o) nst++;
      else done = 1;
    end
    if (!done) begin
      n_vec++; n_err++;
      $display("FAIL stall_timeout: stall_o stuck high, required low within 100 cycles");
    end
    check("stall_cycles", nst, e.lat);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return 32'h8000_0000;
      3:       return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  // monitor: every write must match the oldest outstanding instruction
  always @(negedge clk) begin
    exp_t e;
    if (wen !== 2'b00) begin
      if (sbq.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_write: wen=%b hi=0x%0h lo=0x%0h, required no write (cycle %0d)",
                 wen, hiwdata, lowdata, cyc);
      end else begin
        e = sbq.pop_front();
        check("wen", wen, 2'b11);
        check("hiwdata", hiwdata, e.hi);
        check("lowdata", lowdata, e.lo);
        check("latency", cyc, e.due);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nw;
    #1 reset = 1'b1;
    // start is ignored while reset is high
    start = 1'b1; op = OP_DIVU; src2 = '0;
    @(negedge clk);
    check("rst_stall", stall_o, 1'b0);
    check("rst_wen", wen, 2'b00);
    check("rst_hi", hiwdata, 0);
    check("rst_lo", lowdata, 0);
    @(posedge clk); #1;
    start = 1'b0; reset = 1'b0;
    @(posedge clk); #1;

    // directed cases from the datasheet examples
    issue(OP_MULT,  32'hFFFF_FFFD, 32'd5);
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(OP_DIV,   32'hFFFF_FFF9, 32'd2);
    issue(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
    issue(OP_DIVU,  32'd100,       32'd7);
    issue(OP_DIVU,  32'h1234_5678, 32'd0);
    issue(OP_DIV,   32'hFFFF_FFF9, 32'd0);
    issue(OP_DIV,   32'd7,         32'hFFFF_FFFE);
    issue(OP_MULT,  32'h8000_0000, 32'h8000_0000);

    // flush during DIV: stall drops combinationally, no write follows
    start = 1'b1; op = OP_DIV; src1 = 32'd1000; src2 = 32'd3;
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    check("flush_div_stall", stall_o, 1'b0);
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    nw = 0;
    repeat (30) begin
      @(negedge clk);
      if (wen != 2'b00) nw++;
    end
    check("flush_div_writes", nw, 0);
    @(posedge clk); #1;

    // flush in the DONE cycle of a MULT suppresses the write
    start = 1'b1; op = OP_MULT; src1 = 32'd6; src2 = 32'd7;
    @(posedge clk); #1;
    @(posedge clk); #1;
    flush = 1'b1;
    @(negedge clk);
    check("flush_done_wen", wen, 2'b00);
    check("flush_done_stall", stall_o, 1'b0);
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    @(posedge clk); #1;

    // reset mid-DIV clears everything and no write follows
    start = 1'b1; op = OP_DIVU; src1 = 32'd999; src2 = 32'd10;
    repeat (5) @(posedge clk);
    #1 reset = 1'b1; start = 1'b0;
    #1;
    check("midrst_wen", wen, 2'b00);
    check("midrst_stall", stall_o, 1'b0);
    check("midrst_hi", hiwdata, 0);
    check("midrst_lo", lowdata, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    nw = 0;
    repeat (40) begin
      @(negedge clk);
      if (wen != 2'b00) nw++;
    end
    check("midrst_writes", nw, 0);
    @(posedge clk); #1;

    // randomized mix, sometimes back-to-back, sometimes with idle gaps
    for (int i = 0; i < 50; i++) begin
      issue(2'($urandom_range(0, 3)), pick(), pick());
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end

    repeat (5) @(posedge clk);
    check("scoreboard_empty", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
